// File: rtl/lcd_timing_gen_if.sv
// Panel-side signal bundle of the LCD timing generator: PLL lock in, sync/DE/coordinates out.
// The master side is the timing generator, the slave side is the renderer/panel consumer.
interface lcd_timing_gen_if;
    logic       lock;
    logic       ready;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic       line_start;

    modport master (
        input  lock,
        output ready, hsync, vsync, de, x, y, frame_start, line_start
    );

    modport slave (
        output lock,
        input  ready, hsync, vsync, de, x, y, frame_start, line_start
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Pixel-clock timing generator for the 480x272 RGB panel: qualifies PLL lock, then runs
// h/v counters and emits registered sync, data-enable, coordinates and start pulses.
module lcd_timing_gen #(
    parameter int unsigned H_ACTIVE    = 480,
    parameter int unsigned H_FP        = 2,
    parameter int unsigned H_SYNC      = 41,
    parameter int unsigned H_BP        = 2,
    parameter int unsigned V_ACTIVE    = 272,
    parameter int unsigned V_FP        = 2,
    parameter int unsigned V_SYNC      = 10,
    parameter int unsigned V_BP        = 2,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    lcd_timing_gen_if.master  bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned LW      = $clog2(LOCK_CYCLES + 1);

    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("lcd_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [LW-1:0]   r_lock_cnt;
    logic [9:0]      r_h;
    logic [9:0]      r_v;

    logic            r_ready;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_de;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic            r_frame_start;
    logic            r_line_start;

    logic            w_run_go;
    logic            w_active;
    logic            w_hs;
    logic            w_vs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_LOCK;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_run_go = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                if (bus.lock && r_lock_cnt == LOCK_LAST) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (bus.lock) begin
                    w_run_go = 1'b1;
                end else begin
                    w_next = WAIT_LOCK;
                end
            end
            default: w_next = WAIT_LOCK;
        endcase
    end

    // A lock drop outranks a pending wrap: counters only advance while RUN and locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_cnt <= '0;
            r_h        <= '0;
            r_v        <= '0;
        end else if (w_run_go) begin
            r_lock_cnt <= '0;
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end else begin
            r_h <= '0;
            r_v <= '0;
            if (r_state == WAIT_LOCK && bus.lock && r_lock_cnt != LOCK_LAST) begin
                r_lock_cnt <= r_lock_cnt + LW'(1);
            end else begin
                r_lock_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_active = (r_h < H_ACT) && (r_v < V_ACT);
        w_hs     = (r_h >= HS_BEG) && (r_h < HS_END);
        w_vs     = (r_v >= VS_BEG) && (r_v < VS_END);
    end

    always_ff @(posedge clk) begin
        if (rst || !w_run_go) begin
            r_ready       <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_ready       <= 1'b1;
            r_hsync       <= w_hs ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs ? SYNC_POL : ~SYNC_POL;
            r_de          <= w_active;
            r_x           <= r_h;
            r_y           <= r_v;
            r_frame_start <= (r_h == '0) && (r_v == '0);
            r_line_start  <= (r_h == '0);
        end
    end

    assign bus.ready       = r_ready;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.de          = r_de;
    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.frame_start = r_frame_start;
    assign bus.line_start  = r_line_start;

endmodule
